issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_issue_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: buffers fetched instruction pairs in a 4-entry queue and
// steers up to two per cycle into the load/store and branch issue slots.
module issue_scheduler #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_instr0_i,
    input  logic [31:0] fetch_instr1_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_ready_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        iss_ls_valid_o,
    output logic [31:0] iss_ls_instr_o,
    output logic [31:0] iss_ls_pc_o,
    output logic        iss_bra_valid_o,
    output logic [31:0] iss_bra_instr_o,
    output logic [31:0] iss_bra_pc_o,
    output logic [2:0]  occupancy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StStall} state_e;
    typedef enum logic [1:0] {ClsAlu, ClsMem, ClsBr} cls_e;

    function automatic cls_e classify(input logic [31:0] instr);
        unique case (instr[6:0])
            7'b0000011, 7'b0100011:             return ClsMem;
            7'b1100011, 7'b1101111, 7'b1100111: return ClsBr;
            default:                            return ClsAlu;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [31:0] instr);
        return (instr[6:0] != 7'b0100011) && (instr[6:0] != 7'b1100011) && (instr[11:7] != 5'd0);
    endfunction

    logic [31:0] instr_q [4];
    logic [31:0] pc_q    [4];
    logic [1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, b_ptr;
    logic [2:0]  count_q, count_d, deq_cnt;
    state_e      state_q, state_d;

    logic        ls_valid_q, ls_valid_d, bra_valid_q, bra_valid_d;
    logic [31:0] ls_instr_q, ls_instr_d, ls_pc_q, ls_pc_d;
    logic [31:0] bra_instr_q, bra_instr_d, bra_pc_q, bra_pc_d;

    logic        enq, do_issue, two, a_in_bra, b_fits, raw, waw, co_issue;
    logic [31:0] a_instr, b_instr, a_pc, b_pc;
    cls_e        a_cls, b_cls;

    assign fetch_ready_o = (count_q <= 3'd2) && !flush_i;
    assign enq           = fetch_valid_i && fetch_ready_o;
    assign occupancy_o   = count_q;

    assign b_ptr   = rd_ptr_q + 2'd1;
    assign a_instr = instr_q[rd_ptr_q];
    assign a_pc    = pc_q[rd_ptr_q];
    assign b_instr = instr_q[b_ptr];
    assign b_pc    = pc_q[b_ptr];
    assign a_cls   = classify(a_instr);
    assign b_cls   = classify(b_instr);
    assign two     = count_q >= 3'd2;

    // An ALU head yields the ls slot to a following memory op so the pair can co-issue.
    assign a_in_bra = (a_cls == ClsBr) || ((a_cls == ClsAlu) && two && (b_cls == ClsMem));
    assign b_fits   = a_in_bra ? (b_cls != ClsBr) : (b_cls != ClsMem);
    assign raw      = writes_rd(a_instr) &&
                      ((b_instr[19:15] == a_instr[11:7]) || (b_instr[24:20] == a_instr[11:7]));
    assign waw      = writes_rd(a_instr) && writes_rd(b_instr) && (a_instr[11:7] == b_instr[11:7]);
    assign co_issue = two && (a_cls != ClsBr) && b_fits && !raw && !waw;
    assign do_issue = (state_q == StIssue) && !stall_i && !flush_i && (count_q != 3'd0);
    assign deq_cnt  = do_issue ? (co_issue ? 3'd2 : 3'd1) : 3'd0;

    always_comb begin
        count_d  = count_q + (enq ? 3'd2 : 3'd0) - deq_cnt;
        wr_ptr_d = wr_ptr_q + (enq ? 2'd2 : 2'd0);
        rd_ptr_d = rd_ptr_q + deq_cnt[1:0];
        if (flush_i) begin
            count_d  = 3'd0;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (count_d != 3'd0) state_d = StIssue;
                StIssue: begin
                    if (stall_i)               state_d = StStall;
                    else if (count_d == 3'd0)  state_d = StIdle;
                end
                StStall: if (!stall_i) state_d = StIssue;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        ls_valid_d  = ls_valid_q;
        ls_instr_d  = ls_instr_q;
        ls_pc_d     = ls_pc_q;
        bra_valid_d = bra_valid_q;
        bra_instr_d = bra_instr_q;
        bra_pc_d    = bra_pc_q;
        if (flush_i || !(stall_i || state_q == StStall)) begin
            ls_valid_d  = 1'b0;
            ls_instr_d  = NOP_INSTR;
            ls_pc_d     = 32'd0;
            bra_valid_d = 1'b0;
            bra_instr_d = NOP_INSTR;
            bra_pc_d    = 32'd0;
            if (do_issue) begin
                if (a_in_bra) begin
                    bra_valid_d = 1'b1;
                    bra_instr_d = a_instr;
                    bra_pc_d    = a_pc;
                    if (co_issue) begin
                        ls_valid_d = 1'b1;
                        ls_instr_d = b_instr;
                        ls_pc_d    = b_pc;
                    end
                end else begin
                    ls_valid_d = 1'b1;
                    ls_instr_d = a_instr;
                    ls_pc_d    = a_pc;
                    if (co_issue) begin
                        bra_valid_d = 1'b1;
                        bra_instr_d = b_instr;
                        bra_pc_d    = b_pc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && enq) begin
            instr_q[wr_ptr_q]        <= fetch_instr0_i;
            pc_q[wr_ptr_q]           <= fetch_pc_i;
            instr_q[wr_ptr_q + 2'd1] <= fetch_instr1_i;
            pc_q[wr_ptr_q + 2'd1]    <= fetch_pc_i + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            count_q     <= 3'd0;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            ls_valid_q  <= 1'b0;
            ls_instr_q  <= NOP_INSTR;
            ls_pc_q     <= 32'd0;
            bra_valid_q <= 1'b0;
            bra_instr_q <= NOP_INSTR;
            bra_pc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            ls_valid_q  <= ls_valid_d;
            ls_instr_q  <= ls_instr_d;
            ls_pc_q     <= ls_pc_d;
            bra_valid_q <= bra_valid_d;
            bra_instr_q <= bra_instr_d;
            bra_pc_q    <= bra_pc_d;
        end
    end

    assign iss_ls_valid_o  = ls_valid_q;
    assign iss_ls_instr_o  = ls_instr_q;
    assign iss_ls_pc_o     = ls_pc_q;
    assign iss_bra_valid_o = bra_valid_q;
    assign iss_bra_instr_o = bra_instr_q;
    assign iss_bra_pc_o    = bra_pc_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: slot steering, hazard splits, stall, flush,
// reset override and queue pointer wrap, with hand-computed expectations.
module tb_issue_scheduler;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] LW5   = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] BEQ   = 32'h0031_0063; // beq  x2,x3,0
    localparam logic [31:0] ADDI5 = 32'h0010_0293; // addi x5,x0,1
    localparam logic [31:0] ADD6  = 32'h0022_8333; // add  x6,x5,x2
    localparam logic [31:0] LW7   = 32'h0000_A383; // lw   x7,0(x1)
    localparam logic [31:0] LW8   = 32'h0000_A403; // lw   x8,0(x1)
    localparam logic [31:0] ADDI9A = 32'h0010_0493; // addi x9,x0,1
    localparam logic [31:0] ADDI9B = 32'h0020_0493; // addi x9,x0,2

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] fetch_instr0_i = '0, fetch_instr1_i = '0, fetch_pc_i = '0;
    logic        fetch_ready_o, stall_i = 1'b0, flush_i = 1'b0;
    logic        iss_ls_valid_o, iss_bra_valid_o;
    logic [31:0] iss_ls_instr_o, iss_ls_pc_o, iss_bra_instr_o, iss_bra_pc_o;
    logic [2:0]  occupancy_o;

    int tests = 0;
    int failures = 0;

    issue_scheduler #(.NOP_INSTR(NOP)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_instr0_i (fetch_instr0_i),
        .fetch_instr1_i (fetch_instr1_i),
        .fetch_pc_i     (fetch_pc_i),
        .fetch_ready_o  (fetch_ready_o),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .iss_ls_valid_o (iss_ls_valid_o),
        .iss_ls_instr_o (iss_ls_instr_o),
        .iss_ls_pc_o    (iss_ls_pc_o),
        .iss_bra_valid_o(iss_bra_valid_o),
        .iss_bra_instr_o(iss_bra_instr_o),
        .iss_bra_pc_o   (iss_bra_pc_o),
        .occupancy_o    (occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
        fetch_valid_i  = 1'b1;
        fetch_instr0_i = i0;
        fetch_instr1_i = i1;
        fetch_pc_i     = pc;
    endtask

    task automatic check_ls(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        check({tag, "_ls_v"}, {31'd0, iss_ls_valid_o}, 32'd1);
        check({tag, "_ls_i"}, iss_ls_instr_o, instr);
        check({tag, "_ls_pc"}, iss_ls_pc_o, pc);
    endtask

    task automatic check_bra(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        check({tag, "_bra_v"}, {31'd0, iss_bra_valid_o}, 32'd1);
        check({tag, "_bra_i"}, iss_bra_instr_o, instr);
        check({tag, "_bra_pc"}, iss_bra_pc_o, pc);
    endtask

    function automatic logic [31:0] lw_rd(input int rd);
        return 32'h0000_A003 | (32'(rd) << 7);
    endfunction

    initial begin
        int cnt, pair, issued;
        logic acc, deq;

        // Reset state
        tick(); tick();
        rst_i = 1'b0;
        #1;
        check("rst_occ", {29'd0, occupancy_o}, 32'd0);
        check("rst_ls_v", {31'd0, iss_ls_valid_o}, 32'd0);
        check("rst_ls_i", iss_ls_instr_o, NOP);
        check("rst_ls_pc", iss_ls_pc_o, 32'd0);
        check("rst_bra_v", {31'd0, iss_bra_valid_o}, 32'd0);
        check("rst_bra_i", iss_bra_instr_o, NOP);
        check("rst_ready", {31'd0, fetch_ready_o}, 32'd1);

        // Independent pair co-issues one cycle after enqueue
        fetch(LW5, BEQ, 32'h100);
        tick();
        fetch_valid_i = 1'b0;
        check("ind_lat_occ", {29'd0, occupancy_o}, 32'd2);
        check("ind_lat_v", {31'd0, iss_ls_valid_o}, 32'd0);
        tick();
        check_ls("ind", LW5, 32'h100);
        check_bra("ind", BEQ, 32'h104);
        check("ind_occ", {29'd0, occupancy_o}, 32'd0);
        tick();
        check("ind_after_v", {31'd0, iss_ls_valid_o}, 32'd0);

        // RAW split
        fetch(ADDI5, ADD6, 32'h200);
        tick();
        fetch_valid_i = 1'b0;
        tick();
        check_ls("raw1", ADDI5, 32'h200);
        check("raw1_bra_v", {31'd0, iss_bra_valid_o}, 32'd0);
        check("raw1_occ", {29'd0, occupancy_o}, 32'd1);
        tick();
        check_ls("raw2", ADD6, 32'h204);
        check("raw2_bra_v", {31'd0, iss_bra_valid_o}, 32'd0);
        tick();

        // Two loads contend for the ls slot
        fetch(LW7, LW8, 32'h300);
        tick();
        fetch_valid_i = 1'b0;
        tick();
        check_ls("mm1", LW7, 32'h300);
        check("mm1_bra_v", {31'd0, iss_bra_valid_o}, 32'd0);
        tick();
        check_ls("mm2", LW8, 32'h304);
        tick();

        // WAW split, then stall with four entries queued
        fetch(ADDI9A, ADDI9B, 32'h400);
        tick();
        fetch_valid_i = 1'b0;
        tick();
        check_ls("waw1", ADDI9A, 32'h400);
        check("waw1_bra_v", {31'd0, iss_bra_valid_o}, 32'd0);
        fetch(LW7, LW8, 32'h500);
        tick();
        check_ls("waw2", ADDI9B, 32'h404);
        check("waw2_occ", {29'd0, occupancy_o}, 32'd2);
        fetch(LW5, BEQ, 32'h600);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            fetch_valid_i = 1'b0;
            check_ls("stall", ADDI9B, 32'h404);
            check("stall_occ", {29'd0, occupancy_o}, 32'd4);
            check("stall_ready", {31'd0, fetch_ready_o}, 32'd0);
        end
        stall_i = 1'b0;
        tick();
        check_ls("unstall_hold", ADDI9B, 32'h404);
        check("unstall_occ", {29'd0, occupancy_o}, 32'd4);
        tick();
        check_ls("resume1", LW7, 32'h500);
        check("resume1_occ", {29'd0, occupancy_o}, 32'd3);
        tick();
        check_ls("resume2", LW8, 32'h504);
        check("resume2_bra_v", {31'd0, iss_bra_valid_o}, 32'd0);
        tick();
        check_ls("resume3", LW5, 32'h600);
        check_bra("resume3", BEQ, 32'h604);
        check("resume3_occ", {29'd0, occupancy_o}, 32'd0);

        // Flush with three queued and a fetch pair present
        fetch(LW7, LW8, 32'h700);
        tick();
        fetch(ADDI9A, ADDI9B, 32'h800);
        tick();
        check_ls("pre_flush", LW7, 32'h700);
        check("pre_flush_occ", {29'd0, occupancy_o}, 32'd3);
        fetch(LW5, BEQ, 32'h900);
        flush_i = 1'b1;
        #1;
        check("flush_ready", {31'd0, fetch_ready_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        fetch_valid_i = 1'b0;
        check("flush_occ", {29'd0, occupancy_o}, 32'd0);
        check("flush_ls_v", {31'd0, iss_ls_valid_o}, 32'd0);
        check("flush_ls_i", iss_ls_instr_o, NOP);
        check("flush_ls_pc", iss_ls_pc_o, 32'd0);
        check("flush_bra_v", {31'd0, iss_bra_valid_o}, 32'd0);
        check("flush_bra_i", iss_bra_instr_o, NOP);
        tick();
        check("post_flush_occ", {29'd0, occupancy_o}, 32'd0);
        check("post_flush_ls_v", {31'd0, iss_ls_valid_o}, 32'd0);
        check("post_flush_bra_v", {31'd0, iss_bra_valid_o}, 32'd0);

        // Reset overrides a stall in progress
        stall_i = 1'b1;
        fetch(LW5, BEQ, 32'hA00);
        tick();
        fetch_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        stall_i = 1'b0;
        #1;
        check("rst_stall_ready", {31'd0, fetch_ready_o}, 32'd1);
        check("rst_stall_occ", {29'd0, occupancy_o}, 32'd0);
        fetch(LW5, BEQ, 32'hB00);
        tick();
        fetch_valid_i = 1'b0;
        tick();
        check_ls("rst_stall_issue", LW5, 32'hB00);
        check_bra("rst_stall_issue", BEQ, 32'hB04);
        tick();

        // Pointer wrap: six single-issue load pairs streamed back to back
        cnt = 0;
        pair = 0;
        issued = 0;
        for (int cyc = 0; cyc < 60 && issued < 12; cyc++) begin
            if (pair < 6) fetch(lw_rd(2 * pair + 1), lw_rd(2 * pair + 2), 32'h1000 + 32'(8 * pair));
            else fetch_valid_i = 1'b0;
            #1;
            check("wrap_ready", {31'd0, fetch_ready_o}, {31'd0, cnt <= 2});
            acc = fetch_valid_i && (cnt <= 2);
            deq = cnt >= 1;
            tick();
            if (deq) begin
                check_ls("wrap", lw_rd(issued + 1), 32'h1000 + 32'(4 * issued));
                check("wrap_bra_v", {31'd0, iss_bra_valid_o}, 32'd0);
                issued++;
            end else begin
                check("wrap_idle_v", {31'd0, iss_ls_valid_o}, 32'd0);
            end
            cnt = cnt + (acc ? 2 : 0) - (deq ? 1 : 0);
            if (acc) pair++;
            check("wrap_occ", {29'd0, occupancy_o}, 32'(cnt));
        end
        fetch_valid_i = 1'b0;
        check("wrap_all_issued", 32'(issued), 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
